// File: rtl/data_memory_unit.sv
// Byte-addressable data memory with a fixed-latency request/response handshake.
// Handles RV32I load/store sizes, sign/zero extension and error detection.
module data_memory_unit #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_en,
  input  logic                  Load,
  input  logic                  Store,
  input  logic [2:0]            fun3,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic                  DM_valid,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  mem_err,
  output logic                  busy
);

  localparam int unsigned AW    = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [AW+1:0]           addr_q;
  logic [31:0]             sdata_q;
  logic [2:0]              fun3_q;
  logic                    store_q;

  logic [31:0]             mem [DEPTH_WORDS];

  logic                    req_err_c;
  logic                    f3_ok_c;
  logic                    misal_c;
  logic [DATA_WIDTH-1:0]   rd_result_c;
  logic [31:0]             word_c;
  logic [7:0]              rd_byte_c;
  logic [15:0]             rd_half_c;
  logic [31:0]             wdata_c;
  logic [3:0]              be_c;
  logic                    wr_en_c;
  logic                    unused_addr_c;

  // Upper address bits are intentionally ignored so accesses wrap.
  assign unused_addr_c = ^addr[DATA_WIDTH-1:AW+2];

  // Request classification on the incoming (not yet captured) request.
  always_comb begin
    f3_ok_c = 1'b0;
    misal_c = 1'b0;
    if (Load) f3_ok_c = fun3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else      f3_ok_c = fun3 inside {3'b000, 3'b001, 3'b010};
    if (fun3[1:0] == 2'b01 && addr[0])          misal_c = 1'b1;
    if (fun3[1:0] == 2'b10 && addr[1:0] != 2'b00) misal_c = 1'b1;
    req_err_c = (Load && Store) || !f3_ok_c || misal_c;
  end

  // Load extraction from the captured address.
  always_comb begin
    word_c      = mem[addr_q[AW+1:2]];
    rd_byte_c   = word_c[{addr_q[1:0], 3'b000} +: 8];
    rd_half_c   = word_c[{addr_q[1], 4'b0000} +: 16];
    rd_result_c = DATA_WIDTH'(word_c);
    case (fun3_q)
      3'b000:  rd_result_c = {{(DATA_WIDTH-8){rd_byte_c[7]}}, rd_byte_c};
      3'b100:  rd_result_c = {{(DATA_WIDTH-8){1'b0}}, rd_byte_c};
      3'b001:  rd_result_c = {{(DATA_WIDTH-16){rd_half_c[15]}}, rd_half_c};
      3'b101:  rd_result_c = {{(DATA_WIDTH-16){1'b0}}, rd_half_c};
      default: rd_result_c = DATA_WIDTH'(word_c);
    endcase
  end

  // Store lane replication and byte enables.
  always_comb begin
    wdata_c = sdata_q;
    be_c    = 4'b1111;
    case (fun3_q[1:0])
      2'b00: begin
        wdata_c = {4{sdata_q[7:0]}};
        be_c    = 4'(4'b0001 << addr_q[1:0]);
      end
      2'b01: begin
        wdata_c = {2{sdata_q[15:0]}};
        be_c    = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata_c = sdata_q;
        be_c    = 4'b1111;
      end
    endcase
    wr_en_c = (state == S_WAIT) && (cnt == '0) && store_q && !rst;
  end

  // Memory array: never reset, written on the WAIT->RESP edge.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) mem[addr_q[AW+1:2]][8*i +: 8] <= wdata_c[8*i +: 8];
      end
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      DM_valid  <= 1'b0;
      mem_err   <= 1'b0;
      busy      <= 1'b0;
      load_data <= '0;
      addr_q    <= '0;
      sdata_q   <= '0;
      fun3_q    <= '0;
      store_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          DM_valid <= 1'b0;
          mem_err  <= 1'b0;
          if (mem_en && (Load || Store)) begin
            addr_q  <= addr[AW+1:0];
            sdata_q <= store_data[31:0];
            fun3_q  <= fun3;
            store_q <= Store;
            busy    <= 1'b1;
            if (req_err_c) begin
              state     <= S_RESP;
              DM_valid  <= 1'b1;
              mem_err   <= 1'b1;
              load_data <= '0;
            end else begin
              state <= S_WAIT;
              cnt   <= CNT_W'(MEM_LATENCY - 1);
            end
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            state     <= S_RESP;
            DM_valid  <= 1'b1;
            load_data <= store_q ? '0 : rd_result_c;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          state    <= S_IDLE;
          DM_valid <= 1'b0;
          mem_err  <= 1'b0;
          busy     <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed self-checking bench for data_memory_unit at default parameters.
module tb_data_memory_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en;
  logic        Load;
  logic        Store;
  logic [2:0]  fun3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        DM_valid;
  logic [31:0] load_data;
  logic        mem_err;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  data_memory_unit #(.DATA_WIDTH(32), .DEPTH_WORDS(1024), .MEM_LATENCY(2)) dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .Load(Load), .Store(Store),
    .fun3(fun3), .addr(addr), .store_data(store_data),
    .DM_valid(DM_valid), .load_data(load_data), .mem_err(mem_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_en = 1'b0; Load = 1'b0; Store = 1'b0; fun3 = 3'b000;
    addr = '0; store_data = '0;
  endtask

  // One request; exp_edges counts the acceptance edge as edge 1, 0 = no response.
  task automatic req(input string tag, input logic l, input logic s, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] d, input int exp_edges,
                     input logic exp_err, input logic [31:0] exp_data);
    int seen;
    seen = 0;
    @(negedge clk);
    mem_en = 1'b1; Load = l; Store = s; fun3 = f3; addr = a; store_data = d;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (n == 1) idle_inputs();
      check({tag, "_busy"}, 32'(busy), 32'(exp_edges != 0));
      if (DM_valid) begin
        seen = n;
        break;
      end
    end
    check({tag, "_lat"}, 32'(seen), 32'(exp_edges));
    if (seen != 0) begin
      check({tag, "_err"}, 32'(mem_err), 32'(exp_err));
      check({tag, "_data"}, load_data, exp_data);
      @(posedge clk); #1;
      check({tag, "_pulse"}, 32'(DM_valid), 32'd0);
      check({tag, "_idle"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int pulses, busy_cnt, first_v, second_v;
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(DM_valid), 32'd0);
    check("rst_err", 32'(mem_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", load_data, 32'd0);
    @(negedge clk); rst = 1'b0;

    req("sw10", 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 3, 1'b0, 32'h0);
    req("lw10", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 3, 1'b0, 32'hDEADBEEF);
    req("sb11", 1'b0, 1'b1, 3'b000, 32'h11, 32'h80, 3, 1'b0, 32'h0);
    req("lb11", 1'b1, 1'b0, 3'b000, 32'h11, 32'h0, 3, 1'b0, 32'hFFFFFF80);
    req("lbu11", 1'b1, 1'b0, 3'b100, 32'h11, 32'h0, 3, 1'b0, 32'h00000080);
    req("lw10b", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 3, 1'b0, 32'hDEAD80EF);
    req("lh10", 1'b1, 1'b0, 3'b001, 32'h10, 32'h0, 3, 1'b0, 32'hFFFF80EF);
    req("lhu12", 1'b1, 1'b0, 3'b101, 32'h12, 32'h0, 3, 1'b0, 32'h0000DEAD);
    req("sh12", 1'b0, 1'b1, 3'b001, 32'h12, 32'hCAFE1234, 3, 1'b0, 32'h0);
    req("lw10c", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 3, 1'b0, 32'h123480EF);

    // Error requests and ignored strobe.
    req("sh13", 1'b0, 1'b1, 3'b001, 32'h13, 32'hFFFF, 1, 1'b1, 32'h0);
    req("ldst", 1'b1, 1'b1, 3'b010, 32'h10, 32'h0, 1, 1'b1, 32'h0);
    req("lf3", 1'b1, 1'b0, 3'b011, 32'h10, 32'h0, 1, 1'b1, 32'h0);
    req("sf3", 1'b0, 1'b1, 3'b100, 32'h10, 32'h0, 1, 1'b1, 32'h0);
    req("lwmis", 1'b1, 1'b0, 3'b010, 32'h12, 32'h0, 1, 1'b1, 32'h0);
    req("nop", 1'b0, 1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b0, 32'h0);
    req("lw10d", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 3, 1'b0, 32'h123480EF);

    // Address wrap.
    req("swwrap", 1'b0, 1'b1, 3'b010, 32'h1000, 32'h12345678, 3, 1'b0, 32'h0);
    req("lwwrap", 1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 3, 1'b0, 32'h12345678);

    // Reset during WAIT aborts a store.
    req("sw20", 1'b0, 1'b1, 3'b010, 32'h20, 32'hAAAA5555, 3, 1'b0, 32'h0);
    @(negedge clk);
    mem_en = 1'b1; Store = 1'b1; fun3 = 3'b010; addr = 32'h20; store_data = 32'h11111111;
    @(posedge clk); #1;
    idle_inputs();
    check("abort_busy", 32'(busy), 32'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("abort_valid", 32'(DM_valid), 32'd0);
    check("abort_busy0", 32'(busy), 32'd0);
    check("abort_err", 32'(mem_err), 32'd0);
    check("abort_data", load_data, 32'd0);
    @(negedge clk); rst = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (DM_valid) pulses++;
    end
    check("abort_nopulse", 32'(pulses), 32'd0);
    req("lw20", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 3, 1'b0, 32'hAAAA5555);

    // Held request: accepted again only from IDLE after RESP.
    pulses = 0; busy_cnt = 0; first_v = 0; second_v = 0;
    @(negedge clk);
    mem_en = 1'b1; Load = 1'b1; fun3 = 3'b010; addr = 32'h10;
    for (int n = 1; n <= 14; n++) begin
      @(posedge clk); #1;
      if (n == 8) idle_inputs();
      if (busy) busy_cnt++;
      if (DM_valid) begin
        pulses++;
        if (pulses == 1) first_v = n;
        if (pulses == 2) second_v = n;
        check("b2b_data", load_data, 32'h123480EF);
      end
    end
    check("b2b_pulses", 32'(pulses), 32'd2);
    check("b2b_first", 32'(first_v), 32'd3);
    check("b2b_second", 32'(second_v), 32'd7);
    check("b2b_busy", 32'(busy_cnt), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
